// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one instruction over a req/ack
// handshake, presents it to decode until retired, then selects the next PC.
module fetch_unit #(
  parameter int unsigned          WORD      = 64,
  parameter int unsigned          INSTR_LEN = 32,
  parameter logic [WORD-1:0]      RESET_PC  = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [WORD-1:0]         imem_addr,
  input  logic                    imem_ack,
  input  logic [INSTR_LEN-1:0]    imem_rdata,
  input  logic                    instr_done,
  input  logic                    branch,
  input  logic                    branch_if_zero,
  input  logic                    branch_if_not_zero,
  input  logic                    zero,
  input  logic [WORD-1:0]         extended_instruction,
  output logic [INSTR_LEN-1:0]    instruction,
  output logic                    instr_valid,
  output logic [WORD-1:0]         pc
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [WORD-1:0]        pc_q, pc_d;
  logic [INSTR_LEN-1:0]   instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   req_q, req_d;

  logic                   take;
  logic [WORD-1:0]        seq_pc;
  logic [WORD-1:0]        branch_pc;
  logic [WORD-1:0]        next_pc;

  always_comb begin
    take      = branch | (branch_if_zero & zero) | (branch_if_not_zero & ~zero);
    seq_pc    = pc_q + WORD'(4);
    branch_pc = pc_q + (extended_instruction << 2);
    next_pc   = take ? branch_pc : seq_pc;
  end

  // FETCH with req_q low is the idle cycle right after reset: the request is
  // raised one cycle after reset drops, and any ack seen then is ignored.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    unique case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          req_d = 1'b1;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_done) begin
          pc_d    = {next_pc[WORD-1:2], pc_q[1:0]};
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: begin
        valid_d = 1'b0;
        req_d   = 1'b0;
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: instruction words checked through a queue,
// PC checked against an independent next-PC model; second instance covers wrap.
module tb_fetch_unit;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_done;
  logic        branch, branch_if_zero, branch_if_not_zero, zero;
  logic [63:0] extended_instruction;

  logic        imem_req, instr_valid;
  logic [63:0] imem_addr, pc;
  logic [31:0] instruction;

  logic        imem_req2, instr_valid2;
  logic [63:0] imem_addr2, pc2;
  logic [31:0] instruction2;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] exp_q[$];
  logic [63:0] exp_pc;

  always #5 clk = ~clk;

  fetch_unit #(.WORD(64), .INSTR_LEN(32), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_done(instr_done),
    .branch(branch), .branch_if_zero(branch_if_zero),
    .branch_if_not_zero(branch_if_not_zero), .zero(zero),
    .extended_instruction(extended_instruction),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc)
  );

  fetch_unit #(.WORD(64), .INSTR_LEN(32), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_done(instr_done),
    .branch(branch), .branch_if_zero(branch_if_zero),
    .branch_if_not_zero(branch_if_not_zero), .zero(zero),
    .extended_instruction(extended_instruction),
    .instruction(instruction2), .instr_valid(instr_valid2), .pc(pc2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_presented(input string tag);
    logic [31:0] e;
    check({tag, "_valid"}, {63'd0, instr_valid}, 64'd1);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_instr"}, {32'd0, instruction}, {32'd0, e});
    end
  endtask

  // Called in a cycle where the request is up; ack same cycle, then retire.
  task automatic fetch_retire(input string tag, input logic [31:0] data,
                              input logic br, input logic bz, input logic bnz,
                              input logic z, input logic [63:0] off);
    logic tk;
    check({tag, "_req"},  {63'd0, imem_req}, 64'd1);
    check({tag, "_addr"}, imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = data;
    exp_q.push_back(data);
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    check_presented(tag);
    check({tag, "_pc_hold"}, pc, exp_pc);
    instr_done = 1'b1;
    branch = br; branch_if_zero = bz; branch_if_not_zero = bnz; zero = z;
    extended_instruction = off;
    tk = br | (bz & z) | (bnz & ~z);
    exp_pc = tk ? exp_pc + off * 64'd4 : exp_pc + 64'd4;
    step();
    instr_done = 1'b0;
    branch = 1'b0; branch_if_zero = 1'b0; branch_if_not_zero = 1'b0; zero = 1'b0;
    extended_instruction = '0;
    check({tag, "_pc_next"}, pc, exp_pc);
    check({tag, "_valid_clr"}, {63'd0, instr_valid}, 64'd0);
    check({tag, "_wrap_pc"}, pc2, exp_pc + WRAP_PC);
  endtask

  initial begin
    reset = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0; instr_done = 1'b0;
    branch = 1'b0; branch_if_zero = 1'b0; branch_if_not_zero = 1'b0; zero = 1'b0;
    extended_instruction = '0;
    exp_pc = 64'h0;

    // Reset for two cycles.
    step();
    step();
    check("rst_req",   {63'd0, imem_req}, 64'd0);
    check("rst_valid", {63'd0, instr_valid}, 64'd0);
    check("rst_instr", {32'd0, instruction}, 64'd0);
    check("rst_pc",    pc, 64'h0);
    check("rst_wrap_pc", pc2, WRAP_PC);
    reset = 1'b0;
    step();

    // First fetch with ack in the same cycle as req, plus a stray ack in HOLD.
    check("first_req",  {63'd0, imem_req}, 64'd1);
    check("first_addr", imem_addr, 64'h0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    step();
    check_presented("first");
    check("first_pc",  pc, 64'h0);
    check("hold_req",  {63'd0, imem_req}, 64'd0);
    imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_ack = 1'b0; imem_rdata = '0;
    check("stray_ack_instr", {32'd0, instruction}, 64'h1234_5678);
    check("stray_ack_valid", {63'd0, instr_valid}, 64'd1);
    instr_done = 1'b1;
    exp_pc = 64'h4;
    step();
    instr_done = 1'b0;
    check("seq1_pc",    pc, 64'h4);
    check("seq1_valid", {63'd0, instr_valid}, 64'd0);
    check("wrap_pc",    pc2, 64'h0);

    // Stalled memory: ack arrives 3 cycles after req; stray instr_done in WAIT.
    for (int i = 0; i < 4; i++) begin
      check("stall_req",  {63'd0, imem_req}, 64'd1);
      check("stall_addr", imem_addr, 64'h4);
      check("stall_pc",   pc, 64'h4);
      check("stall_valid", {63'd0, instr_valid}, 64'd0);
      instr_done = (i == 1);
      if (i == 3) begin
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001;
        exp_q.push_back(32'hCAFE_0001);
      end
      step();
      instr_done = 1'b0;
    end
    imem_ack = 1'b0; imem_rdata = '0;
    check_presented("stall");
    check("stall_hold_pc", pc, 64'h4);
    instr_done = 1'b1;
    exp_pc = 64'h8;
    step();
    instr_done = 1'b0;
    check("seq2_pc", pc, 64'h8);

    // Branch directed sequence.
    fetch_retire("br_to_40",  32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 64'd14);
    check("br_to_40_abs", pc, 64'h40);
    fetch_retire("br_neg4",   32'h0000_0011, 1'b1, 1'b0, 1'b0, 1'b0, -64'sd4);
    check("br_neg4_abs", pc, 64'h30);
    fetch_retire("br_to_10",  32'h0000_0012, 1'b1, 1'b0, 1'b0, 1'b0, -64'sd8);
    check("br_to_10_abs", pc, 64'h10);
    fetch_retire("bnz_taken", 32'h0000_0013, 1'b0, 1'b0, 1'b1, 1'b0, 64'd3);
    check("bnz_taken_abs", pc, 64'h1C);
    fetch_retire("br_back",   32'h0000_0014, 1'b1, 1'b0, 1'b0, 1'b1, -64'sd3);
    check("br_back_abs", pc, 64'h10);
    fetch_retire("bz_not",    32'h0000_0015, 1'b0, 1'b1, 1'b0, 1'b0, 64'd7);
    check("bz_not_abs", pc, 64'h14);
    fetch_retire("bz_taken",  32'h0000_0016, 1'b0, 1'b1, 1'b0, 1'b1, 64'd2);
    check("bz_taken_abs", pc, 64'h1C);
    fetch_retire("bnz_not",   32'h0000_0017, 1'b0, 1'b0, 1'b1, 1'b1, 64'd5);
    check("bnz_not_abs", pc, 64'h20);

    // Reset while waiting, with a simultaneous ack that must be discarded.
    step();
    check("wait_req", {63'd0, imem_req}, 64'd1);
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    check("rw_req",   {63'd0, imem_req}, 64'd0);
    check("rw_valid", {63'd0, instr_valid}, 64'd0);
    check("rw_instr", {32'd0, instruction}, 64'h0);
    check("rw_pc",    pc, 64'h0);
    check("rw_wrap_pc", pc2, WRAP_PC);
    step();
    exp_pc = 64'h0;
    fetch_retire("post_rst", 32'hA5A5_5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
